mac_seq_feeder: RTL and testbench

- Sequencer on the drive side of the multiply-accumulate core.
- On a start pulse it clears the core, reads N node/weight pairs from two synchronous-read buffers, and streams them into the core one pair per cycle.
- It counts the core's output valids, captures the final accumulated result, and signals done to the top-level controller.

---
 rtl/mac_seq_feeder.sv | 139 +++++++++++++
 tb/tb_mac_seq_feeder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_feeder.sv
// Drive-side sequencer for the multiply-accumulate core: clears the core,
// streams N node/weight pairs from two synchronous-read buffers, counts the
// core's output valids and captures the final accumulated result.
module mac_seq_feeder #(
  parameter int IN_DATA_WITDH = 8,
  parameter int ADDR_WIDTH    = 8,
  parameter int CNT_WIDTH     = 9
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_start,
  input  logic [CNT_WIDTH-1:0]       i_num_cnt,
  output logic [ADDR_WIDTH-1:0]      o_node_addr,
  output logic                       o_node_ce,
  input  logic [IN_DATA_WITDH-1:0]   i_node_dout,
  output logic [ADDR_WIDTH-1:0]      o_wegt_addr,
  output logic                       o_wegt_ce,
  input  logic [IN_DATA_WITDH-1:0]   i_wegt_dout,
  output logic                       o_run,
  output logic                       o_valid,
  output logic [IN_DATA_WITDH-1:0]   o_node,
  output logic [IN_DATA_WITDH-1:0]   o_wegt,
  input  logic                       i_core_valid,
  input  logic [4*IN_DATA_WITDH-1:0] i_core_result,
  output logic                       o_idle,
  output logic                       o_running,
  output logic                       o_done,
  output logic [4*IN_DATA_WITDH-1:0] o_result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                     state, state_d;
  logic [CNT_WIDTH-1:0]       num, num_d;
  logic [CNT_WIDTH-1:0]       num_m1;
  logic [ADDR_WIDTH-1:0]      addr, addr_d;
  logic [CNT_WIDTH-1:0]       vcnt, vcnt_d;
  logic [4*IN_DATA_WITDH-1:0] result, result_d;
  logic                       ce;
  logic                       valid_q;

  // Last index of the job; the issue counter only needs the low bits since
  // N never exceeds 2^ADDR_WIDTH.
  assign num_m1 = num - CNT_WIDTH'(1);

  // State and datapath registers; reset discards any job in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      num     <= '0;
      addr    <= '0;
      vcnt    <= '0;
      result  <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_d;
      num     <= num_d;
      addr    <= addr_d;
      vcnt    <= vcnt_d;
      result  <= result_d;
      valid_q <= ce;
    end
  end

  // Next-state, counter updates and state-decoded outputs.
  always_comb begin
    state_d   = state;
    num_d     = num;
    addr_d    = addr;
    vcnt_d    = vcnt;
    result_d  = result;
    ce        = 1'b0;
    o_run     = 1'b0;
    o_idle    = 1'b0;
    o_running = 1'b0;
    o_done    = 1'b0;

    case (state)
      S_IDLE: begin
        o_idle = 1'b1;
        if (i_start) begin
          num_d    = i_num_cnt;
          result_d = '0;
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        o_run     = 1'b1;
        o_running = 1'b1;
        addr_d    = '0;
        vcnt_d    = '0;
        state_d   = (num != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        o_running = 1'b1;
        ce        = 1'b1;
        addr_d    = addr + ADDR_WIDTH'(1);
        if (addr == num_m1[ADDR_WIDTH-1:0]) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        o_running = 1'b1;
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Core valids overlap RUN for longer jobs, so they are counted in both
    // RUN and DRAIN; the final one ends the job.
    if ((state == S_RUN || state == S_DRAIN) && i_core_valid) begin
      if (vcnt == num_m1) begin
        result_d = i_core_result;
        state_d  = S_DONE;
      end else begin
        vcnt_d = vcnt + CNT_WIDTH'(1);
      end
    end
  end

  assign o_node_addr = addr;
  assign o_wegt_addr = addr;
  assign o_node_ce   = ce;
  assign o_wegt_ce   = ce;
  assign o_valid     = valid_q;
  // Buffer outputs are already registered; gating keeps operands quiet
  // outside their valid cycle.
  assign o_node      = valid_q ? i_node_dout : '0;
  assign o_wegt      = valid_q ? i_wegt_dout : '0;
  assign o_result    = result;

endmodule

// File: tb/tb_mac_seq_feeder.sv
// Directed bench for mac_seq_feeder with behavioural buffers and a
// two-stage multiply-accumulate core.
module tb_mac_seq_feeder;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int CW = 9;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_start = 1'b0;
  logic [CW-1:0] i_num_cnt = '0;
  logic [AW-1:0] o_node_addr, o_wegt_addr;
  logic          o_node_ce, o_wegt_ce;
  logic [DW-1:0] i_node_dout, i_wegt_dout;
  logic          o_run, o_valid;
  logic [DW-1:0] o_node, o_wegt;
  logic          i_core_valid;
  logic [4*DW-1:0] i_core_result;
  logic          o_idle, o_running, o_done;
  logic [4*DW-1:0] o_result;

  logic [DW-1:0] node_mem [0:255];
  logic [DW-1:0] wegt_mem [0:255];

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cur_cyc = 0;

  mac_seq_feeder #(
    .IN_DATA_WITDH(DW),
    .ADDR_WIDTH   (AW),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_start      (i_start),
    .i_num_cnt    (i_num_cnt),
    .o_node_addr  (o_node_addr),
    .o_node_ce    (o_node_ce),
    .i_node_dout  (i_node_dout),
    .o_wegt_addr  (o_wegt_addr),
    .o_wegt_ce    (o_wegt_ce),
    .i_wegt_dout  (i_wegt_dout),
    .o_run        (o_run),
    .o_valid      (o_valid),
    .o_node       (o_node),
    .o_wegt       (o_wegt),
    .i_core_valid (i_core_valid),
    .i_core_result(i_core_result),
    .o_idle       (o_idle),
    .o_running    (o_running),
    .o_done       (o_done),
    .o_result     (o_result)
  );

  always #5 clk = ~clk;

  // Synchronous-read buffers.
  always_ff @(posedge clk) begin
    if (o_node_ce) i_node_dout <= node_mem[o_node_addr];
    if (o_wegt_ce) i_wegt_dout <= wegt_mem[o_wegt_addr];
  end

  // Core: product stage then accumulate stage, valid two cycles after o_valid.
  logic          v1;
  logic [15:0]   p1;
  logic [31:0]   acc;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1 <= 1'b0; p1 <= '0; i_core_valid <= 1'b0; acc <= '0;
    end else begin
      v1           <= o_valid;
      p1           <= o_node * o_wegt;
      i_core_valid <= v1;
      if (o_run)   acc <= '0;
      else if (v1) acc <= acc + {16'b0, p1};
    end
  end
  assign i_core_result = acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s cyc=%0d: got %0h expected %0h", tag, cur_cyc, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_idle"}, 64'(o_idle), 64'd1);
    chk({tag, "_outs"}, 64'({o_node_addr, o_node_ce, o_wegt_addr, o_wegt_ce, o_run,
                             o_valid, o_node, o_wegt, o_running, o_done}), 64'd0);
    chk({tag, "_result"}, 64'(o_result), 64'd0);
  endtask

  // Runs one job starting at the current negedge (cycle 0) and checks every
  // cycle's outputs up to one cycle past o_done.
  task automatic run_job(input int n, input logic [31:0] exp, input logic [31:0] prev,
                         input bit pulse);
    int done_c;
    done_c  = (n == 0) ? 2 : n + 5;
    cur_cyc = 0;
    chk("c0_idle", 64'(o_idle), 64'd1);
    chk("c0_held", 64'(o_result), 64'(prev));
    i_start   = 1'b1;
    i_num_cnt = CW'(n);
    for (int c = 1; c <= done_c; c++) begin
      @(negedge clk);
      cur_cyc = c;
      chk("run",     64'(o_run), 64'(c == 1));
      chk("ce",      64'(o_node_ce), 64'(c >= 2 && c <= n + 1));
      chk("wce",     64'(o_wegt_ce), 64'(o_node_ce));
      if (c >= 2 && c <= n + 1) begin
        chk("addr",  64'(o_node_addr), 64'(c - 2));
        chk("waddr", 64'(o_wegt_addr), 64'(c - 2));
      end
      chk("valid",   64'(o_valid), 64'(c >= 3 && c <= n + 2));
      if (c >= 3 && c <= n + 2) begin
        chk("node",  64'(o_node), 64'(node_mem[c-3]));
        chk("wegt",  64'(o_wegt), 64'(wegt_mem[c-3]));
      end
      chk("done",    64'(o_done), 64'(c == done_c));
      chk("idle",    64'(o_idle), 64'd0);
      chk("running", 64'(o_running), 64'(c < done_c));
      chk("result",  64'(o_result), (c == done_c) ? 64'(exp) : 64'd0);
      i_start   = pulse && (c == 3 || c == 7);
      i_num_cnt = i_start ? CW'(1) : CW'(n);
    end
    @(negedge clk);
    cur_cyc = done_c + 1;
    chk("after_idle", 64'(o_idle), 64'd1);
    chk("after_held", 64'(o_result), 64'(exp));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      node_mem[i] = '0;
      wegt_mem[i] = '0;
    end

    // Reset state.
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // N=4 basic job: 1*5+2*6+3*7+4*8 = 70.
    for (int i = 0; i < 4; i++) begin
      node_mem[i] = DW'(i + 1);
      wegt_mem[i] = DW'(i + 5);
    end
    run_job(4, 32'd70, 32'd0, 1'b0);

    // Stray starts mid-job are ignored.
    run_job(4, 32'd70, 32'd70, 1'b1);

    // Empty job.
    run_job(0, 32'd0, 32'd70, 1'b0);

    // Full-depth job: 256*255*255.
    for (int i = 0; i < 256; i++) begin
      node_mem[i] = 8'd255;
      wegt_mem[i] = 8'd255;
    end
    run_job(256, 32'd16646400, 32'd0, 1'b0);

    // Back-to-back N=1 jobs, second start in the cycle after o_done.
    node_mem[0] = 8'd9;
    wegt_mem[0] = 8'd9;
    run_job(1, 32'd81, 32'd16646400, 1'b0);
    run_job(1, 32'd81, 32'd81, 1'b0);

    // Reset in cycle 4 of an N=4 job, then a fresh N=2 job: 3*2+4*2 = 14.
    for (int i = 0; i < 4; i++) begin
      node_mem[i] = DW'(i + 1);
      wegt_mem[i] = DW'(i + 5);
    end
    i_start   = 1'b1;
    i_num_cnt = CW'(4);
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    cur_cyc = 4;
    chk("pre_reset_running", 64'(o_running), 64'd1);
    reset_n = 1'b0;
    #1;
    chk_quiet("async_reset");
    @(negedge clk);
    cur_cyc = 5;
    chk_quiet("reset_next");
    reset_n = 1'b1;
    @(negedge clk);
    node_mem[0] = 8'd3; node_mem[1] = 8'd4;
    wegt_mem[0] = 8'd2; wegt_mem[1] = 8'd2;
    run_job(2, 32'd14, 32'd0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
